logic_gate_pipe: RTL

Parametrised, two-stage pipelined bitwise logic unit with valid/ready handshakes on input and output. It applies one of eight selectable gate functions (AND/OR/XOR, their complements, NOT, PASS) to W-bit operands. It provides an internal accumulator that can stand in for operand B, and reports result flags (zero, parity, ones count). It is the generalised, registered successor to the team's fixed 1-bit gate primitives, for use in datapaths that need back-pressure.

---
 rtl/logic_gate_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/logic_gate_pipe.sv
// Two-stage pipelined W-bit logic unit with valid/ready on both sides,
// an accumulator usable as operand B, and zero/parity/ones result flags.
module logic_gate_pipe #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [2:0]    in_op,
  input  logic          in_acc,
  input  logic          acc_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_y,
  output logic          out_zero,
  output logic          out_parity,
  output logic [CW-1:0] out_ones,
  output logic [W-1:0]  acc_value
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_a_q, s1_a_d;
  logic [W-1:0]  s1_b_q, s1_b_d;
  op_e           s1_op_q, s1_op_d;
  logic          s1_acc_q, s1_acc_d;

  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  s2_y_q, s2_y_d;
  logic          s2_zero_q, s2_zero_d;
  logic          s2_par_q, s2_par_d;
  logic [CW-1:0] s2_ones_q, s2_ones_d;

  logic [W-1:0]  acc_q, acc_d;

  logic          s2_free;
  logic          mv;
  logic          push;
  logic [W-1:0]  opb;
  logic [W-1:0]  y;
  logic [CW-1:0] ones;

  assign s2_free  = !s2_valid_q || out_ready;
  assign mv       = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign push     = in_valid && in_ready;

  assign opb = s1_acc_q ? acc_q : s1_b_q;

  always_comb begin
    y = '0;
    unique case (s1_op_q)
      OP_AND:  y = s1_a_q & opb;
      OP_OR:   y = s1_a_q | opb;
      OP_XOR:  y = s1_a_q ^ opb;
      OP_NAND: y = ~(s1_a_q & opb);
      OP_NOR:  y = ~(s1_a_q | opb);
      OP_XNOR: y = ~(s1_a_q ^ opb);
      OP_NOTA: y = ~s1_a_q;
      OP_PASS: y = s1_a_q;
      default: y = '0;
    endcase
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + CW'(y[i]);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_acc_d   = s1_acc_q;
    if (mv) begin
      s1_valid_d = 1'b0;
    end
    if (push) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = op_e'(in_op);
      s1_acc_d   = in_acc;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_zero_d  = s2_zero_q;
    s2_par_d   = s2_par_q;
    s2_ones_d  = s2_ones_q;
    if (s2_valid_q && out_ready) begin
      s2_valid_d = 1'b0;
    end
    if (mv) begin
      s2_valid_d = 1'b1;
      s2_y_d     = y;
      s2_zero_d  = (y == '0);
      s2_par_d   = ^y;
      s2_ones_d  = ones;
    end
  end

  // Clear wins over a same-edge write-back; the result still goes to S2.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (mv && s1_acc_q) begin
      acc_d = y;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_AND;
      s1_acc_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_zero_q  <= 1'b1;
      s2_par_q   <= 1'b0;
      s2_ones_q  <= '0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_acc_q   <= s1_acc_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_zero_q  <= s2_zero_d;
      s2_par_q   <= s2_par_d;
      s2_ones_q  <= s2_ones_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_y      = s2_y_q;
  assign out_zero   = s2_zero_q;
  assign out_parity = s2_par_q;
  assign out_ones   = s2_ones_q;
  assign acc_value  = acc_q;

endmodule
